gumnut_int_ctrl: RTL and testbench

Interrupt controller directly upstream of the Gumnut core. It feeds the core's int_req input and consumes its int_ack output. NUM_SRC external request lines are synchronised, latched and masked, then presented to the core as one request line. The ISR configures the block and queries/acknowledges it through the core's I/O port bus (port address, data, we/stb/cyc, ack).

---
 rtl/gumnut_int_ctrl_pkg.sv | 34 +++
 rtl/gumnut_int_ctrl_if.sv | 21 ++
 rtl/gumnut_int_ctrl_sync_edge.sv | 31 +++
 rtl/gumnut_int_ctrl.sv | 148 ++++++++++++++
 tb/tb_gumnut_int_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gumnut_int_ctrl_pkg.sv
// Shared constants, types and helpers for the Gumnut interrupt controller.
// Register offsets are relative to the controller's base port address.
package gumnut_int_pkg;

    localparam logic [7:0] OFF_IE   = 8'd0;
    localparam logic [7:0] OFF_EDGE = 8'd1;
    localparam logic [7:0] OFF_IP   = 8'd2;
    localparam logic [7:0] OFF_VEC  = 8'd3;
    localparam logic [7:0] OFF_CTRL = 8'd4;
    localparam logic [7:0] OFF_LAST = OFF_CTRL;

    localparam int VEC_INSVC_BIT = 7;
    localparam int VEC_IDX_LSB   = 0;
    localparam int VEC_IDX_W     = 3;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Scanning downwards lets the lowest set index overwrite any higher one.
    function automatic prio_t prio_enc(input logic [7:0] vec);
        prio_t res;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gumnut_int_ctrl_if.sv
// Gumnut I/O port bus as seen by the interrupt controller.
// Signal suffixes follow the controller's direction (it is the slave).
interface gumnut_int_ctrl_if;
    logic [7:0] port_addr_i;
    logic [7:0] port_dat_i;
    logic       port_we_i;
    logic       port_stb_i;
    logic       port_cyc_i;
    logic [7:0] port_dat_o;
    logic       port_ack_o;

    modport master (
        output port_addr_i, port_dat_i, port_we_i, port_stb_i, port_cyc_i,
        input  port_dat_o, port_ack_o
    );

    modport slave (
        input  port_addr_i, port_dat_i, port_we_i, port_stb_i, port_cyc_i,
        output port_dat_o, port_ack_o
    );
endinterface

// File: rtl/gumnut_int_ctrl_sync_edge.sv
// Two-flop synchroniser for one interrupt line, plus rising-edge detect
// against the previous synchronised value.
module int_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_en_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else if (clk_en_i) begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/gumnut_int_ctrl.sv
// Interrupt controller feeding the Gumnut core's int_req/int_ack pair,
// configured and serviced through five registers on the core's I/O port bus.
module gumnut_int_ctrl
    import gumnut_int_pkg::*;
#(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clkEn_i,
    input  logic [NUM_SRC-1:0] irq_i,
    gumnut_int_ctrl_if.slave   bus,
    output logic               int_req_o,
    input  logic               int_ack_i
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    logic [7:0] ie_q, edge_q, ip_q;
    logic       gie_q;
    logic       in_service_q;
    logic [2:0] svc_idx_q;
    logic       req_q;
    logic       ack_q;
    logic [7:0] dat_q;
    logic       held_q;

    logic [7:0] sync_vec, rise_vec;

    logic [7:0] ie_d, edge_d, ip_d;
    logic       gie_d, in_service_d, req_d, held_d;
    logic [2:0] svc_idx_d;
    logic [7:0] dat_d;

    logic [7:0] offset, wdata, rdata, active, ip_clr;
    logic       bus_req, wr, wr_ie, wr_edge, wr_ip, wr_vec, wr_ctrl, ack_fire;
    prio_t      prio;

    for (genvar i = 0; i < 8; i++) begin : g_src
        if (i < NUM_SRC) begin : g_on
            int_sync_edge u_sync (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .clk_en_i (clkEn_i),
                .async_i  (irq_i[i]),
                .sync_o   (sync_vec[i]),
                .rise_o   (rise_vec[i])
            );
        end else begin : g_off
            assign sync_vec[i] = 1'b0;
            assign rise_vec[i] = 1'b0;
        end
    end

    // held_q blocks a strobe kept high past its ack from starting a second access.
    always_comb begin
        offset  = bus.port_addr_i - BASE_ADDR;
        wdata   = bus.port_dat_i & SRC_MASK;
        bus_req = bus.port_cyc_i & bus.port_stb_i & ~ack_q & ~held_q &
                  (offset <= OFF_LAST);
        wr      = bus_req & bus.port_we_i;
        wr_ie   = wr && (offset == OFF_IE);
        wr_edge = wr && (offset == OFF_EDGE);
        wr_ip   = wr && (offset == OFF_IP);
        wr_vec  = wr && (offset == OFF_VEC);
        wr_ctrl = wr && (offset == OFF_CTRL);
        held_d  = bus.port_cyc_i & bus.port_stb_i & (bus_req | held_q);

        rdata = '0;
        case (offset)
            OFF_IE:   rdata = ie_q;
            OFF_EDGE: rdata = edge_q;
            OFF_IP:   rdata = ip_q;
            OFF_VEC: begin
                rdata[VEC_INSVC_BIT]                = in_service_q;
                rdata[VEC_IDX_LSB +: VEC_IDX_W]     = svc_idx_q;
            end
            OFF_CTRL: rdata = {7'd0, gie_q};
            default:  rdata = '0;
        endcase
        dat_d = (bus_req && !bus.port_we_i) ? rdata : 8'd0;
    end

    // Interrupt state: the ack uses the current active vector, while the
    // registered request looks at next-state values so it drops or
    // reasserts exactly one cycle after the causing event.
    always_comb begin
        active   = ip_q & ie_q;
        prio     = prio_enc(active);
        ack_fire = int_ack_i & req_q;

        ip_clr = wr_ip ? wdata : 8'd0;
        if (ack_fire && prio.valid) begin
            ip_clr = ip_clr | (8'd1 << prio.idx);
        end
        ip_d = SRC_MASK & ((edge_q & (rise_vec | (ip_q & ~ip_clr))) |
                           (~edge_q & sync_vec));

        ie_d   = wr_ie   ? wdata : ie_q;
        edge_d = wr_edge ? wdata : edge_q;
        gie_d  = wr_ctrl ? bus.port_dat_i[0] : gie_q;

        in_service_d = in_service_q;
        svc_idx_d    = svc_idx_q;
        if (ack_fire) begin
            in_service_d = 1'b1;
            if (prio.valid) begin
                svc_idx_d = prio.idx;
            end
        end else if (wr_vec) begin
            in_service_d = 1'b0;
        end

        req_d = gie_d & (|(ip_d & ie_d)) & ~in_service_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ie_q         <= '0;
            edge_q       <= '0;
            ip_q         <= '0;
            gie_q        <= 1'b0;
            in_service_q <= 1'b0;
            svc_idx_q    <= '0;
            req_q        <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            held_q       <= 1'b0;
        end else if (clkEn_i) begin
            ie_q         <= ie_d;
            edge_q       <= edge_d;
            ip_q         <= ip_d;
            gie_q        <= gie_d;
            in_service_q <= in_service_d;
            svc_idx_q    <= svc_idx_d;
            req_q        <= req_d;
            ack_q        <= bus_req;
            dat_q        <= dat_d;
            held_q       <= held_d;
        end
    end

    assign int_req_o      = req_q;
    assign bus.port_ack_o = ack_q;
    assign bus.port_dat_o = dat_q;

endmodule

// File: tb/tb_gumnut_int_ctrl.sv
// Directed and randomised bench for gumnut_int_ctrl, checked every cycle
// against a behavioural model of the register and interrupt rules.
module tb_gumnut_int_ctrl;

    localparam int         NUM_SRC   = 8;
    localparam logic [7:0] BASE_ADDR = 8'hF0;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       clkEn_i;
    logic [7:0] irq;
    logic       int_req_o;
    logic       int_ack_i;

    int checks = 0;
    int errors = 0;

    gumnut_int_ctrl_if bus ();

    gumnut_int_ctrl #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE_ADDR)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clkEn_i   (clkEn_i),
        .irq_i     (irq),
        .bus       (bus),
        .int_req_o (int_req_o),
        .int_ack_i (int_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: registers as plain variables, synchroniser as a
    // history of the last three sampled irq vectors.
    logic [7:0] mIe, mEdge, mIp, mDat;
    logic       mGie, mInSvc, mReq, mAck, mBusy;
    logic [2:0] mIdx;
    logic [7:0] hist [3];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mIe = 0; mEdge = 0; mIp = 0; mDat = 0; mGie = 0; mInSvc = 0;
            mReq = 0; mAck = 0; mBusy = 0; mIdx = 0;
            for (int k = 0; k < 3; k++) hist[k] = 0;
        end else if (clkEn_i) begin
            logic [7:0] syncV, riseV, off, act, newIp, rd;
            logic       hit, ackF;
            int         low;
            syncV = hist[1];
            riseV = hist[1] & ~hist[2];
            off   = bus.port_addr_i - BASE_ADDR;
            hit   = bus.port_cyc_i && bus.port_stb_i && !mAck && !mBusy && off < 5;
            act   = mIp & mIe;
            ackF  = int_ack_i && mReq;
            low   = 0;
            while (low < 8 && !act[low]) low++;
            for (int b = 0; b < 8; b++) begin
                if (mEdge[b]) begin
                    if (riseV[b]) newIp[b] = 1'b1;
                    else if ((hit && bus.port_we_i && off == 2 && bus.port_dat_i[b]) ||
                             (ackF && low == b)) newIp[b] = 1'b0;
                    else newIp[b] = mIp[b];
                end else begin
                    newIp[b] = syncV[b];
                end
            end
            case (off)
                0: rd = mIe;
                1: rd = mEdge;
                2: rd = mIp;
                3: rd = {mInSvc, 4'b0000, mIdx};
                4: rd = {7'd0, mGie};
                default: rd = 0;
            endcase
            if (hit && bus.port_we_i) begin
                if (off == 0) mIe   = bus.port_dat_i;
                if (off == 1) mEdge = bus.port_dat_i;
                if (off == 4) mGie  = bus.port_dat_i[0];
            end
            if (ackF) begin
                mInSvc = 1;
                if (low < 8) mIdx = 3'(low);
            end else if (hit && bus.port_we_i && off == 3) begin
                mInSvc = 0;
            end
            mIp   = newIp;
            mReq  = mGie && ((mIp & mIe) != 0) && !mInSvc;
            mDat  = (hit && !bus.port_we_i) ? rd : 8'd0;
            mBusy = bus.port_cyc_i && bus.port_stb_i && (hit || mBusy);
            mAck  = hit;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        checkOutput("int_req", {7'd0, int_req_o}, {7'd0, mReq});
        checkOutput("ack", {7'd0, bus.port_ack_o}, {7'd0, mAck});
        checkOutput("dat", bus.port_dat_o, mDat);
    endtask

    task automatic busIdle();
        bus.port_cyc_i = 0; bus.port_stb_i = 0; bus.port_we_i = 0;
    endtask

    task automatic busDrive(input logic [7:0] off, input logic we, input logic [7:0] data);
        bus.port_addr_i = BASE_ADDR + off;
        bus.port_dat_i  = data;
        bus.port_we_i   = we;
        bus.port_cyc_i  = 1;
        bus.port_stb_i  = 1;
    endtask

    task automatic busWrite(input logic [7:0] off, input logic [7:0] data);
        busDrive(off, 1'b1, data);
        tick();
        busIdle();
        tick();
    endtask

    task automatic busRead(input logic [7:0] off, input logic [7:0] expected, input string tag);
        busDrive(off, 1'b0, 8'h00);
        tick();
        checkOutput({tag, "_ack"}, {7'd0, bus.port_ack_o}, 8'd1);
        checkOutput(tag, bus.port_dat_o, expected);
        busIdle();
        tick();
    endtask

    task automatic pulseIrq0();
        irq[0] = 1;
        tick();
        irq[0] = 0;
        tick();
        tick();
    endtask

    task automatic ackOnce();
        int_ack_i = 1;
        tick();
        int_ack_i = 0;
    endtask

    // Random phase: bus transactions may be held for several cycles,
    // clkEn drops occasionally, irq lines toggle sparsely.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            clkEn_i   = ($urandom_range(0, 7) != 0);
            int_ack_i = ($urandom_range(0, 3) == 0);
            irq       = irq ^ 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    busIdle();
                end else begin
                    busDrive(8'($urandom_range(0, 6)), 1'($urandom), 8'($urandom));
                    if ($urandom_range(0, 15) == 0) bus.port_addr_i = 8'($urandom);
                    if ($urandom_range(0, 9) == 0) bus.port_stb_i = 0;
                end
            end
            tick();
        end
        clkEn_i = 1;
        int_ack_i = 0;
        busIdle();
    endtask

    initial begin
        int ackCount;
        rst_i = 0; clkEn_i = 1; irq = 0; int_ack_i = 0;
        bus.port_addr_i = 0; bus.port_dat_i = 0;
        busIdle();
        repeat (3) @(negedge clk_i);
        rst_i = 1;
        tick();
        checkOutput("rst_req", {7'd0, int_req_o}, 8'd0);
        for (int r = 0; r < 5; r++) busRead(8'(r), 8'h00, "rst_read");

        $display("[TB] edge source 0 request and ack");
        busWrite(0, 8'h05);
        busWrite(1, 8'h01);
        busWrite(4, 8'h01);
        pulseIrq0();
        checkOutput("req_on_edge", {7'd0, int_req_o}, 8'd1);
        busRead(2, 8'h01, "ip_edge");
        ackOnce();
        checkOutput("req_after_ack", {7'd0, int_req_o}, 8'd0);
        busRead(3, 8'h80, "vec_idx0");
        busRead(2, 8'h00, "ip_autoclr");
        busWrite(3, 8'h00);

        $display("[TB] level source 2 with edge source 0");
        irq[2] = 1;
        pulseIrq0();
        tick();
        busRead(2, 8'h05, "ip_both");
        ackOnce();
        busRead(3, 8'h80, "vec_first");
        busDrive(3, 1'b1, 8'h00);
        tick();
        checkOutput("req_after_eoi", {7'd0, int_req_o}, 8'd1);
        busIdle();
        tick();
        ackOnce();
        busRead(3, 8'h82, "vec_second");
        busRead(2, 8'h04, "ip_level");
        busWrite(3, 8'h00);
        irq[2] = 0;
        repeat (4) tick();
        busRead(2, 8'h00, "ip_level_gone");

        $display("[TB] clear racing a new rise");
        pulseIrq0();
        irq[0] = 1;
        tick();
        irq[0] = 0;
        tick();
        busDrive(2, 1'b1, 8'h01);
        tick();
        busIdle();
        tick();
        busRead(2, 8'h01, "w1c_vs_rise");
        busWrite(2, 8'h01);
        busRead(2, 8'h00, "w1c");

        $display("[TB] held strobe and out-of-range access");
        ackCount = 0;
        busDrive(0, 1'b1, 8'h07);
        repeat (4) begin
            tick();
            if (bus.port_ack_o) ackCount++;
        end
        busIdle();
        tick();
        checkOutput("held_stb_acks", 8'(ackCount), 8'd1);
        busRead(0, 8'h07, "ie_after_held");
        ackCount = 0;
        busDrive(5, 1'b1, 8'hFF);
        repeat (2) begin
            tick();
            if (bus.port_ack_o) ackCount++;
        end
        busIdle();
        tick();
        checkOutput("oor_acks", 8'(ackCount), 8'd0);
        busRead(0, 8'h07, "ie_after_oor");
        busRead(1, 8'h01, "edge_after_oor");
        busRead(4, 8'h01, "ctrl_after_oor");

        $display("[TB] reset during service");
        pulseIrq0();
        ackOnce();
        busDrive(3, 1'b0, 8'h00);
        tick();
        checkOutput("vec_before_rst", bus.port_dat_o, 8'h80);
        #2 rst_i = 0;
        #1;
        checkOutput("async_rst_ack", {7'd0, bus.port_ack_o}, 8'd0);
        checkOutput("async_rst_dat", bus.port_dat_o, 8'd0);
        checkOutput("async_rst_req", {7'd0, int_req_o}, 8'd0);
        busIdle();
        tick();
        tick();
        rst_i = 1;
        tick();
        for (int r = 0; r < 5; r++) busRead(8'(r), 8'h00, "post_rst_read");
        irq[2] = 1;
        repeat (5) tick();
        checkOutput("post_rst_no_req", {7'd0, int_req_o}, 8'd0);
        irq = 0;
        repeat (4) tick();

        $display("[TB] randomised traffic");
        busWrite(0, 8'hFF);
        busWrite(1, 8'h0F);
        busWrite(4, 8'h01);
        applyStimulus(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
